// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

    // Primary opcodes (IR[31:26]) and the one funct code the FSM dispatches on.
    localparam logic [5:0] OpRtype    = 6'h00;
    localparam logic [5:0] OpRegimm   = 6'h01;
    localparam logic [5:0] OpJ        = 6'h02;
    localparam logic [5:0] OpBeq      = 6'h04;
    localparam logic [5:0] OpBne      = 6'h05;
    localparam logic [5:0] OpBlez     = 6'h06;
    localparam logic [5:0] OpBgtz     = 6'h07;
    localparam logic [5:0] OpSpecial2 = 6'h1C;
    localparam logic [5:0] OpLw       = 6'h23;
    localparam logic [5:0] OpSw       = 6'h2B;
    localparam logic [5:0] FnJr       = 6'h08;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd, StMemWb,
        StMemWr, StAluWb, StBranch, StJump, StJr, StIllegal
    } state_e;

    typedef enum logic [1:0] {AluAdd, AluSub, AluFunct, AluImm} alu_op_e;
    typedef enum logic [1:0] {SrcBRt, SrcB4, SrcBImm, SrcBImmSh} alu_src_b_e;
    typedef enum logic [1:0] {PcAlu, PcAluOut, PcJump, PcRs} pc_src_e;
    typedef enum logic [2:0] {
        BrNone, BrEq, BrNe, BrGtz, BrGez, BrLez, BrLtz
    } branch_type_e;

    // addi..lui occupy 0x08-0x0F.
    function automatic logic is_imm_alu(logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory access completion: either a ready handshake or a fixed wait-state count.
module mc_mem_wait
    import mc_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic access_i,
    input  logic mem_ready_i,
    output logic done_o
);

    localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

    logic [3:0] cnt_q, cnt_d;

    // Completion pulse and saturating wait counter; cleared between accesses.
    always_comb begin
        if (MEM_HANDSHAKE) begin
            done_o = access_i & mem_ready_i;
        end else begin
            done_o = access_i & (cnt_q == LastCnt);
        end
        cnt_d = cnt_q;
        if (!access_i || done_o) begin
            cnt_d = 4'd0;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM driving the shared-datapath control lines.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LAT       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [2:0] branch_type,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   access, mem_done;

    // Derived from state directly so the completion path has no loop through the decode block.
    assign access = rst_n & ((state_q == StFetch) | (state_q == StMemRd) | (state_q == StMemWr));

    mc_mem_wait #(
        .MEM_HANDSHAKE(MEM_HANDSHAKE),
        .MEM_LAT      (MEM_LAT)
    ) u_mem_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .access_i   (access),
        .mem_ready_i(mem_ready),
        .done_o     (mem_done)
    );

    // Next-state and output decode; everything is held at 0 while in reset.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBRt;
        alu_op        = AluAdd;
        pc_src        = PcAlu;
        branch_type   = BrNone;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcB4;
                if (mem_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = SrcBImmSh;
                if (opcode == OpRtype) begin
                    state_d = (funct == FnJr) ? StJr : StExecR;
                end else if (is_imm_alu(opcode)) begin
                    state_d = StExecI;
                end else if (opcode == OpSpecial2) begin
                    state_d = StExecR;
                end else if (opcode == OpLw || opcode == OpSw) begin
                    state_d = StMemAddr;
                end else if (opcode[5:2] == 4'b0001) begin
                    state_d = StBranch;
                end else if (opcode == OpRegimm) begin
                    state_d = (rt[4:1] == 4'd0) ? StBranch : StIllegal;
                end else if (opcode == OpJ) begin
                    state_d = StJump;
                end else begin
                    state_d = StIllegal;
                end
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBRt;
                alu_op    = AluFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = AluImm;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OpRtype) || (opcode == OpSpecial2);
                state_d   = StFetch;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_done) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_done) state_d = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SrcBRt;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_src        = PcAluOut;
                case (opcode)
                    OpBeq:    branch_type = BrEq;
                    OpBne:    branch_type = BrNe;
                    OpBlez:   branch_type = BrLez;
                    OpBgtz:   branch_type = BrGtz;
                    OpRegimm: branch_type = rt[0] ? BrGez : BrLtz;
                    default:  branch_type = BrNone;
                endcase
                state_d = StFetch;
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = PcJump;
                state_d  = StFetch;
            end
            StJr: begin
                pc_write = 1'b1;
                pc_src   = PcRs;
                state_d  = StFetch;
            end
            default: state_d = StIllegal;
        endcase
        if (!rst_n) begin
            state_d       = StFetch;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SrcBRt;
            alu_op        = AluAdd;
            pc_src        = PcAlu;
            branch_type   = BrNone;
        end
    end

    // Sticky illegal flag, raised as the FSM enters ILLEGAL.
    assign illegal_d  = illegal_q | (state_d == StIllegal);
    assign illegal_op = illegal_q & rst_n;
    assign state      = rst_n ? state_q : 4'd0;

    // State and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench: one handshake instance and one fixed-latency (3) instance.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n_hs, rst_n_fx, mr_hs, mr_fx;
    logic [5:0] opcode, funct;
    logic [4:0] rt;

    logic       pw_h, pwc_h, irw_h, iord_h, mr_o_h, mw_h, rw_h, rd_h, m2r_h, sa_h, ill_h;
    logic [1:0] sb_h, ao_h, ps_h;
    logic [2:0] bt_h;
    logic [3:0] st_h;
    logic       pw_f, pwc_f, irw_f, iord_f, mr_o_f, mw_f, rw_f, rd_f, m2r_f, sa_f, ill_f;
    logic [1:0] sb_f, ao_f, ps_f;
    logic [2:0] bt_f;
    logic [3:0] st_f;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .MEM_LAT(2)) dut_hs (
        .clk(clk), .rst_n(rst_n_hs), .opcode(opcode), .funct(funct), .rt(rt),
        .mem_ready(mr_hs), .pc_write(pw_h), .pc_write_cond(pwc_h), .ir_write(irw_h),
        .iord(iord_h), .mem_read(mr_o_h), .mem_write(mw_h), .reg_write(rw_h),
        .reg_dst(rd_h), .mem_to_reg(m2r_h), .alu_src_a(sa_h), .alu_src_b(sb_h),
        .alu_op(ao_h), .pc_src(ps_h), .branch_type(bt_h), .state(st_h), .illegal_op(ill_h)
    );

    mc_control_fsm #(.MEM_HANDSHAKE(1'b0), .MEM_LAT(3)) dut_fx (
        .clk(clk), .rst_n(rst_n_fx), .opcode(opcode), .funct(funct), .rt(rt),
        .mem_ready(mr_fx), .pc_write(pw_f), .pc_write_cond(pwc_f), .ir_write(irw_f),
        .iord(iord_f), .mem_read(mr_o_f), .mem_write(mw_f), .reg_write(rw_f),
        .reg_dst(rd_f), .mem_to_reg(m2r_f), .alu_src_a(sa_f), .alu_src_b(sb_f),
        .alu_op(ao_f), .pc_src(ps_f), .branch_type(bt_f), .state(st_f), .illegal_op(ill_f)
    );

    wire [23:0] obs_hs = {pw_h, pwc_h, irw_h, iord_h, mr_o_h, mw_h, rw_h, rd_h, m2r_h, sa_h,
                          sb_h, ao_h, ps_h, bt_h, st_h, ill_h};
    wire [23:0] obs_fx = {pw_f, pwc_f, irw_f, iord_f, mr_o_f, mw_f, rw_f, rd_f, m2r_f, sa_f,
                          sb_f, ao_f, ps_f, bt_f, st_f, ill_f};

    // Reference control word for a phase, straight from the per-state output table.
    function automatic logic [23:0] expect_vec(state_e p, logic [5:0] op, logic [4:0] rtv,
                                               logic done);
        logic       pw, pwc, irw, io, mrd, mwr, rw, rd, m2r, sa, ill;
        logic [1:0] sb, ao, ps;
        logic [2:0] bt;
        {pw, pwc, irw, io, mrd, mwr, rw, rd, m2r, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00; bt = 3'd0;
        case (p)
            StFetch:   begin mrd = 1; sb = 2'b01; irw = done; pw = done; end
            StDecode:  sb = 2'b11;
            StExecR:   begin sa = 1; sb = 2'b00; ao = 2'b10; end
            StExecI:   begin sa = 1; sb = 2'b10; ao = 2'b11; end
            StAluWb:   begin rw = 1; rd = (op == 6'h00 || op == 6'h1C); end
            StMemAddr: begin sa = 1; sb = 2'b10; end
            StMemRd:   begin io = 1; mrd = 1; end
            StMemWb:   begin rw = 1; m2r = 1; end
            StMemWr:   begin io = 1; mwr = 1; end
            StBranch: begin
                sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01;
                if (op == 6'h04) bt = 3'd1;
                else if (op == 6'h05) bt = 3'd2;
                else if (op == 6'h07) bt = 3'd3;
                else if (op == 6'h06) bt = 3'd5;
                else bt = (rtv == 5'd1) ? 3'd4 : 3'd6;
            end
            StJump:    begin pw = 1; ps = 2'b10; end
            StJr:      begin pw = 1; ps = 2'b11; end
            StIllegal: ill = 1;
            default:   ;
        endcase
        return {pw, pwc, irw, io, mrd, mwr, rw, rd, m2r, sa, sb, ao, ps, bt, p, ill};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input bit fx, input logic v);
        if (fx) mr_fx = v; else mr_hs = v;
    endtask

    // Hold reset across two edges; every output must read 0 throughout.
    task automatic do_reset(input bit fx);
        if (fx) rst_n_fx = 1'b0; else rst_n_hs = 1'b0;
        set_ready(fx, 1'($urandom));
        #1 chk("reset_forced", fx ? obs_fx : obs_hs, 24'h0);
        @(negedge clk);
        @(negedge clk);
        #1 chk("reset_state", fx ? obs_fx : obs_hs, 24'h0);
        if (fx) rst_n_fx = 1'b1; else rst_n_hs = 1'b1;
    endtask

    // Walks one instruction through its phase sequence; abort_at stops before a given cycle's edge.
    task automatic run_instr(input bit fx, input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] rtv, input int abort_at);
        state_e ph[5];
        int     n, len, cyc;
        logic   last;
        opcode = op; funct = fn; rt = rtv;
        ph[0] = StFetch; ph[1] = StDecode; ph[2] = StIllegal; ph[3] = StFetch; ph[4] = StFetch;
        n = 3;
        if (op == 6'h00) begin
            if (fn == 6'h08) ph[2] = StJr;
            else begin ph[2] = StExecR; ph[3] = StAluWb; n = 4; end
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            ph[2] = StExecI; ph[3] = StAluWb; n = 4;
        end else if (op == 6'h1C) begin
            ph[2] = StExecR; ph[3] = StAluWb; n = 4;
        end else if (op == 6'h23) begin
            ph[2] = StMemAddr; ph[3] = StMemRd; ph[4] = StMemWb; n = 5;
        end else if (op == 6'h2B) begin
            ph[2] = StMemAddr; ph[3] = StMemWr; n = 4;
        end else if ((op >= 6'h04 && op <= 6'h07) || (op == 6'h01 && rtv <= 5'd1)) begin
            ph[2] = StBranch;
        end else if (op == 6'h02) begin
            ph[2] = StJump;
        end
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            if (ph[k] == StFetch || ph[k] == StMemRd || ph[k] == StMemWr) begin
                len = fx ? 3 : 1 + int'($urandom_range(0, 3));
            end else if (ph[k] == StIllegal) begin
                len = 4;
            end else begin
                len = 1;
            end
            for (int c = 0; c < len; c++) begin
                last = (c == len - 1);
                if (fx || !(ph[k] == StFetch || ph[k] == StMemRd || ph[k] == StMemWr))
                    set_ready(fx, 1'($urandom));
                else
                    set_ready(fx, last);
                #1 chk($sformatf("op%02h_ph%0d_c%0d", op, k, c), fx ? obs_fx : obs_hs,
                       expect_vec(ph[k], op, rtv, last));
                if (cyc == abort_at) return;
                cyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_random(input bit fx, input int count);
        logic [5:0] ops[17];
        logic [5:0] op, fn;
        logic [4:0] rtv;
        ops = '{6'h00, 6'h00, 6'h1C, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0F, 6'h23, 6'h2B,
                6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h23};
        for (int i = 0; i < count; i++) begin
            op  = ops[$urandom_range(0, 16)];
            fn  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            rtv = (op == 6'h01) ? 5'($urandom_range(0, 1)) : 5'($urandom);
            run_instr(fx, op, fn, rtv, -1);
        end
    endtask

    initial begin
        rst_n_hs = 1'b0; rst_n_fx = 1'b0; mr_hs = 1'b0; mr_fx = 1'b0;
        opcode = 6'h00; funct = 6'h20; rt = 5'd0;
        @(negedge clk);

        // Handshake instance.
        do_reset(1'b0);
        run_instr(1'b0, 6'h00, 6'h20, 5'd3, -1);
        run_instr(1'b0, 6'h23, 6'h00, 5'd2, -1);
        run_instr(1'b0, 6'h2B, 6'h11, 5'd2, -1);
        run_instr(1'b0, 6'h04, 6'h00, 5'd7, -1);
        run_instr(1'b0, 6'h01, 6'h00, 5'd1, -1);
        run_instr(1'b0, 6'h01, 6'h00, 5'd0, -1);
        run_instr(1'b0, 6'h02, 6'h00, 5'd0, -1);
        run_instr(1'b0, 6'h00, 6'h08, 5'd0, -1);
        run_instr(1'b0, 6'h08, 6'h3F, 5'd9, -1);
        run_random(1'b0, 40);
        run_instr(1'b0, 6'h3F, 6'h00, 5'd0, -1);
        do_reset(1'b0);
        run_instr(1'b0, 6'h01, 6'h00, 5'd2, -1);
        do_reset(1'b0);
        run_instr(1'b0, 6'h00, 6'h21, 5'd0, -1);
        rst_n_hs = 1'b0;

        // Fixed-latency instance.
        do_reset(1'b1);
        run_instr(1'b1, 6'h2B, 6'h00, 5'd4, -1);
        run_instr(1'b1, 6'h23, 6'h00, 5'd4, -1);
        run_instr(1'b1, 6'h00, 6'h20, 5'd4, -1);
        run_random(1'b1, 30);
        // Abandon a store during its second wait cycle, then restart cleanly.
        run_instr(1'b1, 6'h2B, 6'h00, 5'd1, 6);
        do_reset(1'b1);
        run_instr(1'b1, 6'h2B, 6'h00, 5'd1, -1);
        run_instr(1'b1, 6'h3F, 6'h00, 5'd0, -1);
        do_reset(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle MIPS control unit: a Moore/Mealy FSM that sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK for the supported ISA subset and drives the shared-datapath control lines. It replaces the single-cycle decoder in the multi-cycle CPU build. It supports a variable-latency memory port, through either a ready handshake or a fixed wait-state counter. It separates the REGIMM branches (bgez/bltz) by the rt field, and it flags illegal opcodes.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory access completes on mem_ready; 0 = completes after MEM_LAT cycles, mem_ready ignored
- MEM_LAT, 2: fixed access latency in cycles (1..15), used only when MEM_HANDSHAKE=0
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16]; REGIMM select (1 = bgez, 0 = bltz)
- mem_ready  in  1  memory access done this cycle
- pc_write, pc_write_cond, ir_write, iord  out  1  PC / IR / address-mux controls
- mem_read, mem_write  out  1  memory request, held until completion
- reg_write, reg_dst, mem_to_reg, alu_src_a  out  1  datapath controls
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct decode, 11 opcode-immediate decode
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- branch_type  out  3  0 none, 1 eq, 2 ne, 3 gtz, 4 gez, 5 lez, 6 ltz
- state  out  4  current state (debug)
- illegal_op  out  1  sticky illegal-instruction flag

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, JR, ILLEGAL.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. On access completion: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - 0x00 with funct 0x08 → JR
  - other 0x00 → EXEC_R
  - 0x08–0x0F → EXEC_I
  - 0x1C → EXEC_R
  - 0x23, 0x2B → MEM_ADDR
  - 0x04–0x07, 0x01 → BRANCH
  - 0x02 → JUMP
  - anything else → ILLEGAL
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → ALU_WB with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 → ALU_WB with reg_dst=0.
- ALU_WB: reg_write=1, mem_to_reg=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: iord=1, mem_read=1 until completion → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WR: iord=1, mem_write=1 until completion → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. branch_type comes from opcode; opcode 0x01 uses rt (1 → 4, 0 → 6, other → ILLEGAL from DECODE). → FETCH.
- JUMP: pc_write=1, pc_src=10 → FETCH.
- JR: pc_write=1, pc_src=11 → FETCH.
- ILLEGAL: all outputs 0, illegal_op=1, stays until reset.
- Any output not listed for a state is 0.
- Access completion: with MEM_HANDSHAKE=1, mem_ready=1 in a cycle where mem_read or mem_write is asserted. With MEM_HANDSHAKE=0, the wait counter reaches MEM_LAT-1; the counter clears on entry to each access state.

## Timing
- Reset (rst_n=0 at a clock edge): state=FETCH, wait counter=0, illegal_op=0. All outputs are forced to 0 while rst_n=0. First fetch request is issued in the cycle after rst_n rises.
- Cycle counts with zero-wait memory (mem_ready tied 1, or MEM_LAT=1):
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - branch, j, jr: 3
- Each extra memory wait cycle adds 1 to FETCH, MEM_RD or MEM_WR.
- ir_write/pc_write in FETCH, and the exit from access states, are Mealy on completion. All other outputs are pure Moore.
- mem_ready asserted while no request is active is ignored.
- Reset mid-access abandons the access. No partial register or PC write occurs after the reset edge.
- Wait counter is 4 bits and saturates at 15; it never wraps.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode/funct constants
  - state enum (4-bit)
  - alu_op, alu_src_b, pc_src and branch_type encodings
- Sub-module mc_mem_wait generates the completion pulse from MEM_HANDSHAKE, MEM_LAT, mem_ready and an access-active input. It contains the wait counter.
- FSM next-state logic and output decode live in mc_control_fsm.

## Test plan
- add (opcode 0, funct 0x20), mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1, reg_dst=1 only in cycle 4; next FETCH in cycle 5.
- lw with MEM_HANDSHAKE=1, mem_ready low for 3 cycles in MEM_RD → mem_read and iord held 4 cycles; MEM_WB follows with reg_write=1, mem_to_reg=1; total 8 cycles.
- MEM_HANDSHAKE=0, MEM_LAT=3, sw → FETCH lasts 3 cycles, MEM_WR lasts 3 cycles with mem_write=1; mem_ready toggling has no effect.
- opcode 0x01 with rt=1 → branch_type=4; with rt=0 → branch_type=6; both with pc_write_cond=1 and pc_src=01 in BRANCH.
- jr (opcode 0, funct 0x08) → JR state with pc_write=1, pc_src=11; opcode 0x3F → ILLEGAL, illegal_op=1, all other outputs 0 until rst_n=0.
- rst_n pulled low during MEM_WR wait → next cycle state=FETCH, mem_write=0; after release, fetch restarts cleanly.
